// File: rtl/shift_counter_pkg.sv
// Shared definitions for the multi-mode shift-register counter family:
// mode encodings, LFSR tap table and per-mode sequence period.
package shift_counter_pkg;

    typedef enum logic [1:0] {
        MODE_RING    = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_HOLD    = 2'b11
    } shiftMode_t;

    // Maximal-length tap masks, bit i set means q[i] feeds the XOR.
    function automatic logic [7:0] lfsrTaps(input int width);
        case (width)
            3:       return 8'b0000_0110;
            4:       return 8'b0000_1100;
            5:       return 8'b0001_0100;
            6:       return 8'b0011_0000;
            7:       return 8'b0110_0000;
            8:       return 8'b1011_1000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic int period(input logic [1:0] mode, input int width);
        case (mode)
            MODE_RING:    return width;
            MODE_JOHNSON: return 2 * width;
            MODE_LFSR:    return (1 << width) - 1;
            default:      return 1;
        endcase
    endfunction

endpackage

// File: rtl/shift_counter_fb.sv
// Combinational next-state selection for ring, Johnson and LFSR modes,
// including the LFSR all-zero lockup escape.
module shift_counter_fb
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] nextQ,
    output logic             lockFix
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsrTaps(WIDTH));

    logic fb;
    logic shiftRight;

    // The LFSR always shifts toward the MSB, so dir only matters for ring/Johnson.
    always_comb begin
        fb         = 1'b0;
        shiftRight = dir && (mode != MODE_LFSR);
        lockFix    = 1'b0;
        case (mode)
            MODE_RING:    fb = dir ? q[0] : q[WIDTH-1];
            MODE_JOHNSON: fb = dir ? ~q[0] : ~q[WIDTH-1];
            MODE_LFSR:    fb = ^(q & TAPS);
            default:      fb = 1'b0;
        endcase
        nextQ = shiftRight ? {fb, q[WIDTH-1:1]} : {q[WIDTH-2:0], fb};
        if (mode == MODE_LFSR && q == '0) begin
            nextQ   = {{(WIDTH-1){1'b0}}, 1'b1};
            lockFix = 1'b1;
        end
        if (mode == MODE_HOLD) begin
            nextQ = q;
        end
    end

endmodule

// File: rtl/shift_counter_gen.sv
// Run-time selectable ring / Johnson / LFSR sequence generator with
// parallel load and a count-based period-wrap pulse.
module shift_counter_gen
    import shift_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             lock_fix
);

    if (WIDTH < 3 || WIDTH > 8) begin : gWidthCheck
        $error("shift_counter_gen: WIDTH must be within 3..8");
    end

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0] LAST_RING    = (WIDTH+1)'(period(MODE_RING, WIDTH) - 1);
    localparam logic [WIDTH:0] LAST_JOHNSON = (WIDTH+1)'(period(MODE_JOHNSON, WIDTH) - 1);
    localparam logic [WIDTH:0] LAST_LFSR    = (WIDTH+1)'(period(MODE_LFSR, WIDTH) - 1);

    logic [WIDTH:0]   cnt;
    logic [WIDTH:0]   lastCnt;
    logic [1:0]       prevMode;
    logic [WIDTH-1:0] stepQ;
    logic             stepFix;
    logic             step;
    logic             modeChanged;

    shift_counter_fb #(.WIDTH(WIDTH)) uFb (
        .q       (q),
        .mode    (mode),
        .dir     (dir),
        .nextQ   (stepQ),
        .lockFix (stepFix)
    );

    assign step        = en && (mode != MODE_HOLD);
    assign modeChanged = (mode != prevMode);

    always_comb begin
        lastCnt = '0;
        case (mode)
            MODE_RING:    lastCnt = LAST_RING;
            MODE_JOHNSON: lastCnt = LAST_JOHNSON;
            MODE_LFSR:    lastCnt = LAST_LFSR;
            default:      lastCnt = '0;
        endcase
    end

    // A step taken on a mode-change edge is the first step of the new mode's period.
    always_ff @(posedge clk) begin
        prevMode <= mode;
        wrap     <= 1'b0;
        lock_fix <= 1'b0;
        if (rst) begin
            q   <= RST_Q;
            cnt <= '0;
        end else if (load) begin
            q   <= d;
            cnt <= '0;
        end else if (step) begin
            q        <= stepQ;
            lock_fix <= stepFix;
            if (modeChanged) begin
                cnt <= (WIDTH+1)'(1);
            end else if (cnt == lastCnt) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (modeChanged) begin
            cnt <= '0;
        end
    end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Self-checking bench for shift_counter_gen (WIDTH=4): directed sequences
// followed by randomized traffic against a behavioural pattern model.
module tb_shift_counter_gen;

    logic       clk = 1'b0;
    logic       rst, en, load, dir;
    logic [3:0] d;
    logic [1:0] mode;
    logic [3:0] q;
    logic       wrap, lock_fix;

    int total = 0;
    int bad   = 0;

    int   mq;
    int   mSteps;
    int   mPrev;
    logic expWrap, expFix;

    int ringSeq[4]   = '{2, 4, 8, 1};
    int john0Seq[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};
    int john1Seq[8]  = '{8, 12, 14, 15, 7, 3, 1, 0};
    int lfsrSeq[15]  = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};

    always #5 clk = ~clk;

    shift_counter_gen #(.WIDTH(4), .RST_VAL(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .d        (d),
        .mode     (mode),
        .dir      (dir),
        .q        (q),
        .wrap     (wrap),
        .lock_fix (lock_fix)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int refPeriod(input int m);
        case (m)
            0:       return 4;
            1:       return 8;
            default: return 15;
        endcase
    endfunction

    // Pattern model: rotation, twisted-ring and Fibonacci LFSR as integer arithmetic.
    task automatic modelUpdate(input logic r, input logic l, input logic e,
                               input int dv, input int m, input logic dr);
        expWrap = 1'b0;
        expFix  = 1'b0;
        if (r) begin
            mq     = 1;
            mSteps = 0;
        end else if (l) begin
            mq     = dv & 15;
            mSteps = 0;
        end else begin
            if (m != mPrev) mSteps = 0;
            if (e && m != 3) begin
                case (m)
                    0: mq = dr ? ((mq >> 1) | ((mq & 1) << 3)) : (((mq << 1) | (mq >> 3)) & 15);
                    1: mq = dr ? ((mq >> 1) | (((~mq) & 1) << 3)) : (((mq << 1) & 15) | ((~mq >> 3) & 1));
                    default: begin
                        if (mq == 0) begin
                            mq     = 1;
                            expFix = 1'b1;
                        end else begin
                            mq = ((mq << 1) & 15) | ($countones(mq & 12) % 2);
                        end
                    end
                endcase
                mSteps++;
                if (mSteps % refPeriod(m) == 0) expWrap = 1'b1;
            end
        end
        mPrev = m;
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input int dv, input int m, input logic dr);
        rst  = r;
        load = l;
        en   = e;
        d    = dv[3:0];
        mode = m[1:0];
        dir  = dr;
        @(posedge clk);
        #1;
        modelUpdate(r, l, e, dv, m, dr);
        checkOutput("q", int'(q), mq);
        checkOutput("wrap", int'(wrap), int'(expWrap));
        checkOutput("lock_fix", int'(lock_fix), int'(expFix));
    endtask

    initial begin
        int m;
        rst = 1'b1; load = 1'b0; en = 1'b0; d = '0; mode = '0; dir = 1'b0;
        mq = 0; mSteps = 0; mPrev = 0;

        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_q", int'(q), 1);
        checkOutput("reset_wrap", int'(wrap), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkOutput("ring_seq", int'(q), ringSeq[i]);
            checkOutput("ring_wrap", int'(wrap), int'(i == 3));
        end
        applyStimulus(0, 0, 1, 0, 0, 0);

        applyStimulus(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 0);
            checkOutput("john0_seq", int'(q), john0Seq[i]);
            checkOutput("john0_wrap", int'(wrap), int'(i == 7));
        end
        applyStimulus(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 1, 0, 1, 1);
            checkOutput("john1_seq", int'(q), john1Seq[i]);
            checkOutput("john1_wrap", int'(wrap), int'(i == 7));
        end

        applyStimulus(0, 1, 0, 1, 2, 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 0, 1, 0, 2, $urandom_range(0, 1));
            checkOutput("lfsr_seq", int'(q), lfsrSeq[i]);
            checkOutput("lfsr_wrap", int'(wrap), int'(i == 14));
        end

        applyStimulus(0, 1, 0, 0, 2, 0);
        applyStimulus(0, 0, 1, 0, 2, 0);
        checkOutput("lockup_q", int'(q), 1);
        checkOutput("lockup_fix", int'(lock_fix), 1);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 0, 1, 0, 2, 0);
            checkOutput("lockup_fix_clear", int'(lock_fix), 0);
        end
        checkOutput("lockup_wrap", int'(wrap), 1);

        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 10, 0, 0);
        checkOutput("load_over_en", int'(q), 10);
        checkOutput("load_wrap", int'(wrap), 0);
        applyStimulus(1, 1, 1, 6, 0, 0);
        checkOutput("rst_over_load", int'(q), 1);

        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        repeat (3) begin
            applyStimulus(0, 0, 1, 0, 3, 0);
            checkOutput("hold_q", int'(q), 4);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            checkOutput("resume_wrap", int'(wrap), int'(i == 3));
        end

        m = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) m = int'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), m,
                          $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
Parametrised multi-mode shift-register counter: ring, Johnson, or maximal-length LFSR, selectable at run time.
- WIDTH-bit state with parallel load, count enable and shift direction.
- A step counter emits a one-cycle period-wrap pulse.
- Serves as the generic sequence/phase generator for the counter family, replacing fixed 4-bit ring/Johnson counters.

Parameters:
WIDTH, 4, state width; legal range 3..8 (LFSR tap table covers this range only).
RST_VAL, 1, value of q after reset (WIDTH bits, zero-extended/truncated).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  advance one step when high.
load  in  1  parallel load of d; priority over en.
d  in  WIDTH  load value / seed.
mode  in  2  00 ring, 01 Johnson, 10 LFSR, 11 hold.
dir  in  1  0 shift toward MSB, 1 shift toward LSB (ring/Johnson only).
q  out  WIDTH  current state, registered.
wrap  out  1  registered pulse, high for the cycle in which q holds the state reached by the step completing a full period.
lock_fix  out  1  registered pulse, LFSR escaped all-zero lockup on this step.

Behaviour:
- Reset (rst=1 at edge): q=RST_VAL, step count cnt=0, wrap=0, lock_fix=0. rst overrides load and en.
- Priority per edge: rst > load > en. Otherwise hold; wrap/lock_fix return to 0 on any non-stepping cycle.
- load=1: q<=d, cnt<=0, wrap<=0, lock_fix<=0, regardless of en.
- A step happens when en=1, load=0, rst=0 and mode!=11. mode=11 behaves as en=0.
- dir=0: q<={q[W-2:0],fb}. dir=1: q<={fb,q[W-1:1]}.
- Ring: fb=q[W-1] (dir0) or q[0] (dir1). All-zero and multi-hot patterns simply rotate; no correction. PERIOD=WIDTH.
- Johnson: fb=~q[W-1] (dir0) or ~q[0] (dir1). PERIOD=2*WIDTH.
- LFSR: always dir0 (dir ignored). fb = XOR of tap bits from package table (WIDTH=4: q[3]^q[2]). PERIOD=2^WIDTH-1.
- LFSR lockup: if q==0 on a step, q<=1 and lock_fix<=1 for that cycle. That step still counts toward cnt.
- Step counter: cnt width = WIDTH+1 bits. On a step, if cnt==PERIOD-1 then cnt<=0 and wrap<=1; else cnt<=cnt+1 and wrap<=0.
- wrap is count-based, not pattern-based. It asserts together with the q update of the PERIOD-th step after reset/load/mode change.
- Mode change: when mode at an edge differs from the mode registered at the previous edge, cnt<=0 with q unchanged. If a step also occurs, it uses the new mode and cnt<=1 (or wraps if PERIOD=1, which cannot occur).
- dir change mid-run does not reset cnt.
- Latency: q, wrap and lock_fix change one edge after the controlling inputs. No combinational input-to-output paths.
- WIDTH outside 3..8: elaboration error via generate-time check.

Decomposition:
- Package shift_counter_pkg holds:
  - mode encodings (MODE_RING, MODE_JOHNSON, MODE_LFSR, MODE_HOLD);
  - the LFSR tap-mask function/constant table indexed by WIDTH (3:0b110, 4:0b1100, 5:0b10100, 6:0b110000, 7:0b1100000, 8:0b10111000);
  - a period function period(mode, WIDTH).
- One sub-module, shift_counter_fb: combinational next-state/feedback selection from (q, mode, dir).
- The top holds q, cnt, previous-mode register and the pulses.

Test Plan:
1. WIDTH=4, rst 3 cycles then release, mode=00, dir=0, en=1 -> q: 0001, 0010, 0100, 1000, 0001; wrap high only with the 4th step (q=0001).
2. load d=0000, mode=01, dir=0, en=1 -> q: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap on the 8th step only. Repeat with dir=1 -> 1000, 1100, 1110, 1111, 0111, ...
3. load d=0001, mode=10 -> 15 distinct states: 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001; wrap on the 15th step; never 0000.
4. Force LFSR via load d=0000, en=1 -> next q=0001, lock_fix=1 for one cycle; cnt=1.
5. Simultaneous load=1, en=1, d=1010 mid-sequence -> q=1010, cnt=0, wrap=0. rst=1 with load=1 -> q=RST_VAL.
6. Ring mid-run at cnt=2, switch mode to 11 for 3 cycles -> q frozen, wrap=0. Return to mode=00 -> cnt restarts at 0, wrap after 4 further steps.
